// File: rtl/aes_mixcol_fwd_serial.sv
// rtl/aes_mixcol_fwd_serial.sv - column-serial AES MixColumns unit (optional inverse via AES_MIXCOL_INV_EN)
`timescale 1ns/1ps
module aes_mixcol_fwd_serial (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
`ifdef AES_MIXCOL_INV_EN
    ,
    input  logic         inv
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [127:0]  work_q, work_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   col_in;
    logic [31:0]   col_out;
    logic [31:0]   col_fwd;
    logic [7:0]    a0, a1, a2, a3;

    // GF(2^8) multiply by 2 with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        mul3 = xtime(x) ^ x;
    endfunction

`ifdef AES_MIXCOL_INV_EN
    logic        inv_q, inv_d;
    logic [31:0] col_inv;

    // Inverse coefficients built from x, 2x, 4x, 8x of each byte
    function automatic logic [7:0] mul9(input logic [7:0] x);
        mul9 = xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] x);
        mul11 = xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] x);
        mul13 = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] x);
        mul14 = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction
`endif

    // Select the column currently being transformed (column 0 is the top word)
    always_comb begin
        col_in = work_q[127:96];
        case (col_q)
            2'd0:    col_in = work_q[127:96];
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            default: col_in = work_q[31:0];
        endcase
    end

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Single shared column engine; row i uses the coefficient row rotated by i
    always_comb begin
        col_fwd = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                   mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
`ifdef AES_MIXCOL_INV_EN
        col_inv = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                   mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                   mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                   mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
        col_out = inv_q ? col_inv : col_fwd;
`else
        col_out = col_fwd;
`endif
    end

    // Next-state, working-register update and output decodes
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
`ifdef AES_MIXCOL_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    col_d   = 2'd0;
                    state_d = BUSY;
`ifdef AES_MIXCOL_INV_EN
                    inv_d   = inv;
`endif
                end
            end
            BUSY: begin
                case (col_q)
                    2'd0:    work_d[127:96] = col_out;
                    2'd1:    work_d[95:64]  = col_out;
                    2'd2:    work_d[63:32]  = col_out;
                    default: work_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and registered handshake outputs; reset abandons any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef AES_MIXCOL_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule
